// File: rtl/wrr_stream_arbiter.sv
// Weighted round-robin stream arbiter with burst credits and a payload mux.
// Forward path is combinational; a stalled decision stays locked until it transfers.
module wrr_stream_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int WEIGHT_WIDTH = 4,
  parameter int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ*WEIGHT_WIDTH-1:0] weight_i,
  output logic                          gnt_valid_o,
  input  logic                          gnt_ready_i,
  output logic [DATA_WIDTH-1:0]         gnt_data_o,
  output logic [IDX_W-1:0]              gnt_idx_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        lock_idx_q, lock_idx_d;
  logic [WEIGHT_WIDTH-1:0] cnt_q, cnt_d;
  logic                    lock_q, lock_d;

  logic [IDX_W-1:0]        sel;
  logic [IDX_W-1:0]        cand;
  logic [WEIGHT_WIDTH-1:0] w_ptr;
  logic                    found;
  logic                    extend;
  logic                    burst;
  logic                    xfer;
  logic                    stall;

  always_comb begin
    w_ptr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IDX_W'(k) == ptr_q) begin
        w_ptr = weight_i[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
    end
    if (w_ptr == '0) begin
      w_ptr = WEIGHT_WIDTH'(1);
    end
  end

  assign extend = (cnt_q != '0) && (cnt_q < w_ptr);
  assign burst  = extend && req_valid_i[ptr_q];

  // Search starts just after the last-served index; ptr_q itself is checked last.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    if (lock_q && req_valid_i[lock_idx_q]) begin
      sel = lock_idx_q;
    end else if (burst) begin
      sel = ptr_q;
    end else begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
        if (!found && req_valid_i[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  assign gnt_valid_o = |req_valid_i;
  assign gnt_idx_o   = sel;
  assign xfer        = gnt_valid_o & gnt_ready_i;
  assign stall       = gnt_valid_o & ~gnt_ready_i;

  always_comb begin
    gnt_data_o  = '0;
    req_ready_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_valid_o && IDX_W'(k) == sel) begin
        gnt_data_o     = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        req_ready_o[k] = gnt_ready_i;
      end
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    lock_d     = 1'b0;
    lock_idx_d = lock_idx_q;
    if (xfer) begin
      ptr_d = sel;
      cnt_d = (sel == ptr_q && extend) ? cnt_q + WEIGHT_WIDTH'(1)
                                       : WEIGHT_WIDTH'(1);
    end else if (stall) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      ptr_q      <= LAST_IDX;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

`ifndef SYNTHESIS
  a_ready_onehot0: assert property (@(posedge clk_i)
    $onehot0(req_ready_o));
  a_ready_xfer: assert property (@(posedge clk_i)
    (|req_ready_o) |-> xfer);
  a_lock_stable: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    (lock_q && req_valid_i[lock_idx_q]) |-> $stable(gnt_data_o));
`endif

endmodule

// File: tb/tb_wrr_stream_arbiter.sv
// Bench for wrr_stream_arbiter: directed scenarios then constrained-random traffic
// checked cycle by cycle against a behavioural model of the arbitration rules.
module tb_wrr_stream_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int WW = 4;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            flush_i = 1'b0;
  logic [N-1:0]    req_valid_i = '0;
  logic [N-1:0]    req_ready_o;
  logic [N*DW-1:0] req_data_i = '0;
  logic [N*WW-1:0] weight_i = '0;
  logic            gnt_valid_o;
  logic            gnt_ready_i = 1'b0;
  logic [DW-1:0]   gnt_data_o;
  logic [1:0]      gnt_idx_o;

  int checks = 0;
  int failures = 0;
  int m_last;
  int m_burst;
  int m_lock;
  logic [N-1:0] served = '0;

  wrr_stream_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_data_i(req_data_i), .weight_i(weight_i),
    .gnt_valid_o(gnt_valid_o), .gnt_ready_i(gnt_ready_i),
    .gnt_data_o(gnt_data_o), .gnt_idx_o(gnt_idx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int credit(input int k);
    int w;
    w = int'(weight_i[k*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic logic [DW-1:0] pay(input int k);
    return req_data_i[k*DW +: DW];
  endfunction

  function automatic int pick();
    if (req_valid_i == '0) return 0;
    if (m_lock >= 0 && req_valid_i[m_lock]) return m_lock;
    if (m_burst > 0 && m_burst < credit(m_last) && req_valid_i[m_last])
      return m_last;
    for (int i = 1; i <= N; i++)
      if (req_valid_i[(m_last + i) % N]) return (m_last + i) % N;
    return 0;
  endfunction

  task automatic model_step(input int s);
    if (rst_i || flush_i) begin
      m_last = N - 1; m_burst = 0; m_lock = -1;
    end else if (req_valid_i == '0) begin
      m_lock = -1;
    end else if (!gnt_ready_i) begin
      m_lock = s;
    end else begin
      if (s == m_last && m_burst > 0 && m_burst < credit(m_last))
        m_burst = m_burst + 1;
      else
        m_burst = 1;
      m_last = s;
      m_lock = -1;
    end
  endtask

  task automatic tick(input int exp_idx);
    int s;
    logic any;
    #2;
    s = pick();
    any = |req_valid_i;
    chk("gnt_valid", 64'(gnt_valid_o), 64'(any));
    chk("gnt_idx", 64'(gnt_idx_o), 64'(s));
    chk("gnt_data", 64'(gnt_data_o), any ? 64'(pay(s)) : 64'd0);
    chk("req_ready", 64'(req_ready_o),
        (any && gnt_ready_i) ? 64'(1) << s : 64'd0);
    if (exp_idx >= 0) chk("dir_idx", 64'(gnt_idx_o), 64'(exp_idx));
    served = req_ready_o;
    model_step(s);
    @(posedge clk_i);
    #1;
    chk("ptr_q", 64'(dut.ptr_q), 64'(m_last));
    chk("cnt_q", 64'(dut.cnt_q), 64'(m_burst));
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick(-1);
    rst_i = 1'b0;
  endtask

  task automatic set_w(input int k, input int w);
    weight_i[k*WW +: WW] = WW'(w);
  endtask

  int seq_rr[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
  int seq_w31[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  int seq_w0[4]  = '{0, 2, 0, 2};
  int cnt_seq[4] = '{1, 2, 1, 2};

  initial begin
    for (int k = 0; k < N; k++) req_data_i[k*DW +: DW] = 32'hD0D0_0000 + k;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    m_last = N - 1; m_burst = 0; m_lock = -1;
    #2;
    chk("rst_valid", 64'(gnt_valid_o), 64'd0);
    chk("rst_idx", 64'(gnt_idx_o), 64'd0);
    chk("rst_data", 64'(gnt_data_o), 64'd0);
    chk("rst_ready", 64'(req_ready_o), 64'd0);
    chk("rst_ptr", 64'(dut.ptr_q), 64'd3);
    chk("rst_cnt", 64'(dut.cnt_q), 64'd0);
    chk("rst_lock", 64'(dut.lock_q), 64'd0);

    for (int k = 0; k < N; k++) set_w(k, 1);
    req_valid_i = 4'b1111; gnt_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) tick(seq_rr[i]);

    do_reset();
    set_w(0, 3); set_w(1, 1);
    req_valid_i = 4'b0011;
    for (int i = 0; i < 8; i++) tick(seq_w31[i]);

    do_reset();
    for (int k = 0; k < N; k++) set_w(k, 1);
    req_valid_i = 4'b1100; gnt_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) req_valid_i[0] = 1'b1;
      tick(2);
    end
    gnt_ready_i = 1'b1;
    tick(2); tick(3); tick(0);

    do_reset();
    for (int k = 0; k < N; k++) set_w(k, 0);
    req_valid_i = 4'b0101;
    for (int i = 0; i < 4; i++) tick(seq_w0[i]);

    do_reset();
    set_w(0, 3); set_w(1, 1);
    req_valid_i = 4'b0011;
    tick(0); tick(0);
    flush_i = 1'b1;
    tick(-1);
    flush_i = 1'b0;
    chk("flush_ptr", 64'(dut.ptr_q), 64'd3);
    chk("flush_cnt", 64'(dut.cnt_q), 64'd0);
    tick(0);
    chk("flush_cnt1", 64'(dut.cnt_q), 64'd1);
    tick(0); tick(0); tick(1);

    do_reset();
    set_w(1, 2);
    req_valid_i = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("burst_cnt", 64'(dut.cnt_q), 64'(cnt_seq[i]));
    end

    do_reset();
    for (int k = 0; k < N; k++) set_w(k, 1);
    req_valid_i = 4'b1100; gnt_ready_i = 1'b0;
    tick(2);
    req_valid_i = 4'b1000;
    tick(3);
    gnt_ready_i = 1'b1;
    tick(3);

    do_reset();
    served = '0;
    for (int c = 0; c < 600; c++) begin
      if (c % 40 == 0)
        for (int k = 0; k < N; k++) set_w(k, $urandom_range(0, 4));
      for (int k = 0; k < N; k++) begin
        if (!(req_valid_i[k] && !served[k])) begin
          req_valid_i[k] = ($urandom_range(0, 2) != 0);
          req_data_i[k*DW +: DW] = $urandom;
        end
      end
      gnt_ready_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 59) == 0);
      tick(-1);
      if (flush_i) served = '0;
      flush_i = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
